conv_controller: RTL and testbench
==================================

# conv_controller

Sequencing FSM for the convolution datapath. On `start` it resets the datapath counters, then loads filter weights into the N processing elements. It then loads the first 4x4 input window and, for each of 13 window positions, runs a 16-cycle MAC pass and writes back the result, sliding the window between positions. It drives every `rst*`/`en*`/`sel`/`wr`/`shift` input of the datapath and consumes its carry-outs.

## Interface
- `N`, 4, number of PEs; width of `en1` is 16*N.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `cout3` in 1: window-position counter at terminal value (13th position).
- `cout5` in 1: MAC element counter at 15.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `sel` out 2: address mux select; 0 = X (input), 1 = Y (output), 2 = Z (filter).
- `wr`, `shift`, `en10`, `en12`, `rst12` out 1 each: PE write, buffer shift, PE output enable, accumulate enable, accumulator clear.
- `rst3`, `rst5`, `rst6`, `rst7`, `rst8`, `rst9`, `rst11`, `rstN` out 1 each: datapath counter clears.
- `en3`, `en5`, `en6`, `en7`, `en8`, `en9`, `en11` out 1 each: datapath counter enables.
- `en2` out 16: row-load enables of the 4x16 window buffer.
- `en4` out 16: mask register load enables.
- `en1` out 16*N: filter-register load enables; slice `[16p+15:16p]` belongs to PE p.

## Operation
- Moore FSM. Outputs decode from state plus internal counters `p` (PE index, clog2(N) bits), `q` (quarter 0..3) and `r` (row 0..3). Any output not listed for a state is 0.
- IDLE: `start`=1 goes to INIT. `busy`=0.
- INIT (1 cycle): all `rst*`=1; clear `p`, `q`, `r`. Go to FLT.
- FLT (4N cycles):
  - Outputs: `sel`=2, `en7`=1, `en8`=1; `en1` slice p = `16'h000F << 4q`.
  - `q` increments each cycle. On `q`=3, `p` increments and `q` wraps.
  - Leave on `p`=N-1 and `q`=3, going to WIN.
- WIN (4 cycles): `sel`=0, `en6`=1, `en11`=1, `en2`=`16'h000F << 4r`; `r` increments. Leave on `r`=3, going to MASK.
- MASK (1 cycle): `en4`=16'hFFFF, `rst5`=1. Go to MAC.
- MAC (16 cycles): `en5`=1, `en12`=1. Leave when `cout5`=1, going to WB.
- WB (1 cycle):
  - Outputs: `sel`=1, `wr`=1, `en10`=1, `en9`=1, `rst12`=1.
  - If `cout3`=1, go to DONE; else go to SLIDE.
- SLIDE (1 cycle): `shift`=1, `en3`=1, `sel`=0, `en6`=1, `en2`=16'hF000 (new column into last row slot). Go to MASK.
- DONE (1 cycle): `done`=1. Go to IDLE.
- `start` outside IDLE is ignored. `start` held high in IDLE after DONE starts a new frame immediately.
- The controller never asserts `en*` and the matching `rst*` in the same cycle, except `en12`/`rst12`, which are never co-asserted either (MAC vs WB).

## Timing
- Reset:
  - State becomes IDLE on the first clock edge with `rst`=1.
  - All outputs are 0 from that edge onward, `busy`=0, `done`=0.
  - `rst` mid-frame aborts without a write. Datapath counters are not cleared until the next INIT.
- `start` sampled at edge 0: INIT occupies cycle 1.
  - FLT occupies cycles 2..4N+1; WIN occupies 4N+2..4N+5.
  - Each position costs 18 cycles (MASK + 16 MAC + WB). 12 SLIDE cycles sit between the 13 positions.
  - `done` is high in cycle 4N+252 (268 for N=4); IDLE follows in cycle 4N+253.
- `cout5` is sampled in MAC only. If it is asserted on the first MAC cycle, exit after 1 cycle; no minimum is enforced.
- `cout3` is sampled in WB only.

## Structure
- Shared package `conv_ctrl_pkg` holds:
  - the state enum (IDLE, INIT, FLT, WIN, MASK, MAC, WB, SLIDE, DONE);
  - `SEL_X`=0, `SEL_Y`=1, `SEL_Z`=2;
  - `MAC_LEN`=16, `POSITIONS`=13, `WIN_ROWS`=4.
- One sub-module, `ctrl_en_decode`, is combinational. It maps (state, `p`, `q`, `r`) to `en1`/`en2`/`en4`. The FSM and the `p`/`q`/`r` counters stay in `conv_controller`.

## Test plan
- Reset, then `start` pulse, N=4, `cout5` modelled at MAC cycle 16, `cout3` at WB 13 -> INIT at cycle 1, `done` exactly in cycle 268, `busy` high in cycles 1..268.
- During FLT with N=2 -> `en1` takes the values `0x000F`, `0x00F0`, `0x0F00`, `0xF000` in slice 0, then the same in slice 1; `sel`=2 and `en7`=1 for all 8 cycles.
- WIN then SLIDE -> `en2` = `0x000F`, `0x00F0`, `0x0F00`, `0xF000` over 4 cycles; SLIDE shows `shift`=1, `en2`=`0xF000`, `en3`=1.
- `cout3`=1 on the first WB -> next state DONE, no SLIDE, `done` pulses once.
- `rst`=1 in the middle of MAC -> all outputs 0 and `busy`=0 at the next edge; a following `start` replays INIT with all `rst*`=1.
- `start` pulsed during MAC -> ignored; frame length and `done` timing unchanged.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | conv_ctrl_pkg                                                        |
// | Shared states, mux selects and sequencing constants for the          |
// | convolution controller.                                              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package conv_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        FLT   = 4'd2,
        WIN   = 4'd3,
        MASK  = 4'd4,
        MAC   = 4'd5,
        WB    = 4'd6,
        SLIDE = 4'd7,
        DONE  = 4'd8
    } state_t;

    localparam logic [1:0] SEL_X = 2'd0;
    localparam logic [1:0] SEL_Y = 2'd1;
    localparam logic [1:0] SEL_Z = 2'd2;

    localparam int MAC_LEN   = 16;
    localparam int POSITIONS = 13;
    localparam int WIN_ROWS  = 4;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_ctrl_if.sv
// +----------------------------------------------------------------------+
// | conv_ctrl_if                                                         |
// | Controller <-> convolution datapath control bundle.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface conv_ctrl_if #(
    parameter int N = 4
);
    logic            start;
    logic            cout3;
    logic            cout5;
    logic            busy;
    logic            done;
    logic [1:0]      sel;
    logic            wr, shift, en10, en12, rst12;
    logic            rst3, rst5, rst6, rst7, rst8, rst9, rst11, rstN;
    logic            en3, en5, en6, en7, en8, en9, en11;
    logic [15:0]     en2;
    logic [15:0]     en4;
    logic [16*N-1:0] en1;

    // Master is the controller; slave is the datapath/stimulus side.
    modport master (
        input  start, cout3, cout5,
        output busy, done, sel, wr, shift, en10, en12, rst12,
               rst3, rst5, rst6, rst7, rst8, rst9, rst11, rstN,
               en3, en5, en6, en7, en8, en9, en11, en2, en4, en1
    );
    modport slave (
        output start, cout3, cout5,
        input  busy, done, sel, wr, shift, en10, en12, rst12,
               rst3, rst5, rst6, rst7, rst8, rst9, rst11, rstN,
               en3, en5, en6, en7, en8, en9, en11, en2, en4, en1
    );
endinterface

`default_nettype wire

// File: rtl/ctrl_en_decode.sv
// +----------------------------------------------------------------------+
// | ctrl_en_decode                                                       |
// | Combinational decode of filter/window/mask load enables.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ctrl_en_decode
    import conv_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  state_t          state_i,
    input  logic [PW-1:0]   p_i,
    input  logic [1:0]      q_i,
    input  logic [1:0]      r_i,
    output logic [16*N-1:0] en1_o,
    output logic [15:0]     en2_o,
    output logic [15:0]     en4_o
);

    for (genvar pe = 0; pe < N; pe++) begin : g_pe
        assign en1_o[16*pe +: 16] = (state_i == FLT && p_i == PW'(pe))
                                  ? (16'h000F << {q_i, 2'b00}) : 16'h0000;
    end

    always_comb begin
        en2_o = 16'h0000;
        en4_o = 16'h0000;
        case (state_i)
            WIN:     en2_o = 16'h000F << {r_i, 2'b00};
            // A slide brings one new column into the last row slot.
            SLIDE:   en2_o = 16'hF000;
            MASK:    en4_o = 16'hFFFF;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/conv_controller.sv
// +----------------------------------------------------------------------+
// | conv_controller                                                      |
// | Sequencing FSM for the convolution datapath (filter, window, MAC).   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module conv_controller
    import conv_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst,
    conv_ctrl_if.master bus
);

    localparam int PW = ptr_width(N);

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [1:0]    q_q, q_d;
    logic [1:0]    r_q, r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        r_d     = r_q;
        case (state_q)
            IDLE:  if (bus.start) state_d = INIT;
            INIT: begin
                p_d     = '0;
                q_d     = '0;
                r_d     = '0;
                state_d = FLT;
            end
            FLT: begin
                q_d = q_q + 2'd1;
                if (q_q == 2'd3) begin
                    p_d = p_q + 1'b1;
                    if (p_q == PW'(N - 1)) state_d = WIN;
                end
            end
            WIN: begin
                r_d = r_q + 2'd1;
                if (r_q == 2'(WIN_ROWS - 1)) state_d = MASK;
            end
            MASK:  state_d = MAC;
            MAC:   if (bus.cout5) state_d = WB;
            WB:    state_d = bus.cout3 ? DONE : SLIDE;
            SLIDE: state_d = MASK;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.done  = 1'b0;
        bus.sel   = SEL_X;
        bus.wr    = 1'b0;
        bus.shift = 1'b0;
        bus.en10  = 1'b0;
        bus.en12  = 1'b0;
        bus.rst12 = 1'b0;
        bus.rst3  = 1'b0;
        bus.rst5  = 1'b0;
        bus.rst6  = 1'b0;
        bus.rst7  = 1'b0;
        bus.rst8  = 1'b0;
        bus.rst9  = 1'b0;
        bus.rst11 = 1'b0;
        bus.rstN  = 1'b0;
        bus.en3   = 1'b0;
        bus.en5   = 1'b0;
        bus.en6   = 1'b0;
        bus.en7   = 1'b0;
        bus.en8   = 1'b0;
        bus.en9   = 1'b0;
        bus.en11  = 1'b0;
        case (state_q)
            INIT: begin
                bus.rst3  = 1'b1;
                bus.rst5  = 1'b1;
                bus.rst6  = 1'b1;
                bus.rst7  = 1'b1;
                bus.rst8  = 1'b1;
                bus.rst9  = 1'b1;
                bus.rst11 = 1'b1;
                bus.rst12 = 1'b1;
                bus.rstN  = 1'b1;
            end
            FLT: begin
                bus.sel = SEL_Z;
                bus.en7 = 1'b1;
                bus.en8 = 1'b1;
            end
            WIN: begin
                bus.en6  = 1'b1;
                bus.en11 = 1'b1;
            end
            MASK: bus.rst5 = 1'b1;
            MAC: begin
                bus.en5  = 1'b1;
                bus.en12 = 1'b1;
            end
            WB: begin
                bus.sel   = SEL_Y;
                bus.wr    = 1'b1;
                bus.en10  = 1'b1;
                bus.en9   = 1'b1;
                bus.rst12 = 1'b1;
            end
            SLIDE: begin
                bus.shift = 1'b1;
                bus.en3   = 1'b1;
                bus.en6   = 1'b1;
            end
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

    ctrl_en_decode #(
        .N  (N),
        .PW (PW)
    ) u_decode (
        .state_i (state_q),
        .p_i     (p_q),
        .q_i     (q_q),
        .r_i     (r_q),
        .en1_o   (bus.en1),
        .en2_o   (bus.en2),
        .en4_o   (bus.en4)
    );

endmodule

`default_nettype wire

// File: tb/tb_conv_controller.sv
// +----------------------------------------------------------------------+
// | tb_conv_controller                                                   |
// | Self-checking bench: N=2 filter-load table plus planned N=4 frames.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_conv_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_ctrl_if #(.N(4)) if1 ();
    conv_ctrl_if #(.N(2)) if2 ();

    conv_controller #(.N(4)) u_dut  (.clk(clk), .rst(rst), .bus(if1));
    conv_controller #(.N(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct packed {
        logic        busy, done;
        logic [1:0]  sel;
        logic        wr, shift, en10, en12, rst12;
        logic        rst3, rst5, rst6, rst7, rst8, rst9, rst11, rstN;
        logic        en3, en5, en6, en7, en8, en9, en11;
        logic [15:0] en2, en4;
        logic [63:0] en1;
    } out_t;

    typedef struct {
        logic start, cout5, cout3;
        out_t exp;
    } step_t;

    typedef struct {
        logic        cout5, cout3;
        logic [31:0] en1;
        logic [15:0] en2;
        logic [1:0]  sel;
        logic        en7, busy;
    } vec2_t;

    step_t plan[$];
    vec2_t tv[10];
    int    vectors     = 0;
    int    miscompares = 0;
    bit    noise       = 1'b0;

    function automatic out_t sample1();
        out_t o;
        o.busy = if1.busy;   o.done = if1.done;   o.sel = if1.sel;
        o.wr = if1.wr;       o.shift = if1.shift; o.en10 = if1.en10;
        o.en12 = if1.en12;   o.rst12 = if1.rst12; o.rst3 = if1.rst3;
        o.rst5 = if1.rst5;   o.rst6 = if1.rst6;   o.rst7 = if1.rst7;
        o.rst8 = if1.rst8;   o.rst9 = if1.rst9;   o.rst11 = if1.rst11;
        o.rstN = if1.rstN;   o.en3 = if1.en3;     o.en5 = if1.en5;
        o.en6 = if1.en6;     o.en7 = if1.en7;     o.en8 = if1.en8;
        o.en9 = if1.en9;     o.en11 = if1.en11;   o.en2 = if1.en2;
        o.en4 = if1.en4;     o.en1 = if1.en1;
        return o;
    endfunction

    task automatic check(input string name, input int idx, input out_t exp);
        out_t act;
        act = sample1();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // c5/c3 < 0 marks a cycle where the controller must ignore that input.
    task automatic push(input out_t o, input int c5, input int c3);
        step_t s;
        s.exp   = o;
        s.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        s.cout5 = (c5 < 0) ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : c5[0];
        s.cout3 = (c3 < 0) ? (noise ? 1'($urandom_range(0, 1)) : 1'b0) : c3[0];
        plan.push_back(s);
    endtask

    // Expected cycle-by-cycle behaviour of one N=4 frame with the given
    // number of positions and per-position MAC lengths.
    task automatic build_plan(input int npos, input int lens[13]);
        out_t o;
        plan.delete();
        o = '0; o.busy = 1'b1;
        {o.rst3, o.rst5, o.rst6, o.rst7, o.rst8, o.rst9, o.rst11, o.rst12, o.rstN} = '1;
        push(o, -1, -1);
        for (int p = 0; p < 4; p++)
            for (int q = 0; q < 4; q++) begin
                o = '0; o.busy = 1'b1; o.sel = 2'd2; o.en7 = 1'b1; o.en8 = 1'b1;
                o.en1 = 64'hF << (16 * p + 4 * q);
                push(o, -1, -1);
            end
        for (int r = 0; r < 4; r++) begin
            o = '0; o.busy = 1'b1; o.en6 = 1'b1; o.en11 = 1'b1;
            o.en2 = 16'hF << (4 * r);
            push(o, -1, -1);
        end
        for (int pos = 1; pos <= npos; pos++) begin
            o = '0; o.busy = 1'b1; o.en4 = 16'hFFFF; o.rst5 = 1'b1;
            push(o, -1, -1);
            for (int m = 1; m <= lens[pos-1]; m++) begin
                o = '0; o.busy = 1'b1; o.en5 = 1'b1; o.en12 = 1'b1;
                push(o, (m == lens[pos-1]) ? 1 : 0, -1);
            end
            o = '0; o.busy = 1'b1; o.sel = 2'd1; o.wr = 1'b1; o.en10 = 1'b1;
            o.en9 = 1'b1; o.rst12 = 1'b1;
            push(o, -1, (pos == npos) ? 1 : 0);
            if (pos < npos) begin
                o = '0; o.busy = 1'b1; o.shift = 1'b1; o.en3 = 1'b1; o.en6 = 1'b1;
                o.en2 = 16'hF000;
                push(o, -1, -1);
            end
        end
        o = '0; o.busy = 1'b1; o.done = 1'b1;
        push(o, -1, -1);
    endtask

    // Entered and left just after a rising edge with the DUT in IDLE.
    task automatic run_plan(input string name, input int abort_at);
        int done_cyc;
        done_cyc = -1;
        if1.start = 1'b1;
        if1.cout5 = 1'b0;
        if1.cout3 = 1'b0;
        @(negedge clk);
        check({name, "_idle"}, -1, '0);
        @(posedge clk); #1;
        foreach (plan[i]) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                if1.start = 1'b0;
                @(negedge clk);
                check({name, "_abort"}, i, '0);
                @(posedge clk); #1;
                return;
            end
            if1.start = plan[i].start;
            if1.cout5 = plan[i].cout5;
            if1.cout3 = plan[i].cout3;
            @(negedge clk);
            check(name, i + 1, plan[i].exp);
            if (if1.done === 1'b1 && done_cyc < 0) done_cyc = i + 1;
            @(posedge clk); #1;
        end
        if1.start = 1'b0;
        check_int({name, "_done_cycle"}, done_cyc, plan.size());
    endtask

    int lens[13];
    int npos;

    initial begin
        tv[0] = '{1'b0, 1'b0, 32'h0, 16'h0, 2'd0, 1'b0, 1'b1};
        tv[1] = '{1'b0, 1'b0, 32'h0000_000F, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[2] = '{1'b0, 1'b0, 32'h0000_00F0, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[3] = '{1'b0, 1'b0, 32'h0000_0F00, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[4] = '{1'b0, 1'b0, 32'h0000_F000, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[5] = '{1'b0, 1'b0, 32'h000F_0000, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[6] = '{1'b0, 1'b0, 32'h00F0_0000, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[7] = '{1'b0, 1'b0, 32'h0F00_0000, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[8] = '{1'b0, 1'b0, 32'hF000_0000, 16'h0, 2'd2, 1'b1, 1'b1};
        tv[9] = '{1'b0, 1'b0, 32'h0, 16'h000F, 2'd0, 1'b0, 1'b1};

        if1.start = 1'b1; if1.cout5 = 1'b1; if1.cout3 = 1'b1;
        if2.start = 1'b1; if2.cout5 = 1'b0; if2.cout3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset", 0, '0);
        vectors++;
        if (if2.busy !== 1'b0 || if2.en1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_n2: busy %b en1 %h expected 0 0", if2.busy, if2.en1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        if1.start = 1'b0;
        if1.cout5 = 1'b0;
        if1.cout3 = 1'b0;

        // N=2 filter-load table; if2.start is high so INIT follows this edge.
        @(posedge clk); #1;
        if2.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if2.cout5 = tv[i].cout5;
            if2.cout3 = tv[i].cout3;
            @(negedge clk);
            vectors++;
            if (if2.en1 !== tv[i].en1 || if2.en2 !== tv[i].en2 || if2.sel !== tv[i].sel ||
                if2.en7 !== tv[i].en7 || if2.en8 !== tv[i].en7 || if2.busy !== tv[i].busy) begin
                miscompares++;
                $display("FAIL n2_table %0d: got en1=%h en2=%h sel=%0d en7=%b en8=%b busy=%b expected en1=%h en2=%h sel=%0d en7=%b busy=%b",
                         i, if2.en1, if2.en2, if2.sel, if2.en7, if2.en8, if2.busy,
                         tv[i].en1, tv[i].en2, tv[i].sel, tv[i].en7, tv[i].busy);
            end
            @(posedge clk); #1;
        end
        if2.cout5 = 1'b1;
        if2.cout3 = 1'b1;

        foreach (lens[k]) lens[k] = 16;
        noise = 1'b0;
        build_plan(13, lens);
        run_plan("frame_full", -1);

        noise = 1'b1;
        build_plan(13, lens);
        run_plan("frame_noise", -1);

        lens[0] = 1;
        build_plan(1, lens);
        run_plan("frame_one_pos", -1);

        lens[0] = 16;
        build_plan(13, lens);
        run_plan("frame_abort", 27);
        build_plan(13, lens);
        run_plan("frame_after_abort", -1);

        for (int f = 0; f < 5; f++) begin
            npos = $urandom_range(1, 13);
            foreach (lens[k]) lens[k] = $urandom_range(1, 16);
            build_plan(npos, lens);
            run_plan("frame_rand", -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
